// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Covers FSM states, port ownership, wait-counter width and the legal LATENCY range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = (1 << CNT_W) - 1;

  // One-hot grant encoding shared by the selector and the top.
  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  function automatic bit latency_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selector for the I/D memory ports; produces a one-hot grant.
// MEM_ARB_RR_EN selects round-robin on collisions, otherwise D has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  // last_grant is 1 when D was the previous winner, so a collision goes to I.
  always_comb begin
    grant = '0;
    if (i_req && d_req) begin
      grant = last_grant ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = '0;
    if (d_req) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 16-bit memory between fetch (I) and memory-stage (D) ports,
// spending LATENCY cycles per access. Build with MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic [15:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_done,
  output logic [15:0]           d_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  output logic                  mem_enable,
  output logic                  mem_wr,
  input  logic [15:0]           mem_data_out
);

  if (!latency_ok(LATENCY)) begin : g_latency_check
    $error("mem_arbiter: LATENCY must be in 1..15");
  end

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  owner_t                owner;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [15:0]           lat_wdata;
  logic                  lat_wr;
  logic [1:0]            grant;
  logic                  accept;
  logic                  last_grant_d;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_d),
    .grant      (grant)
  );

  assign accept = (state == IDLE) && (|grant);

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_I;
    end else if (accept) begin
      last_grant <= grant[1] ? OWN_D : OWN_I;
    end
  end

  assign last_grant_d = (last_grant == OWN_D);
`else
  assign last_grant_d = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (|grant) begin
          if (LATENCY == 1) begin
            state_next = ACCESS;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = ACCESS;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request fields are captured at accept so requesters may change them mid-access.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_I;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
    end else if (accept) begin
      owner     <= grant[1] ? OWN_D : OWN_I;
      lat_addr  <= grant[1] ? d_addr : i_addr;
      lat_wdata <= grant[1] ? d_wdata : 16'h0000;
      lat_wr    <= grant[1] & d_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if ((state == ACCESS) && !lat_wr) begin
      if (owner == OWN_D) begin
        d_rdata <= mem_data_out;
      end else begin
        i_rdata <= mem_data_out;
      end
    end
  end

  // rst gating keeps the memory untouched while it loads its image.
  assign mem_enable  = (state == ACCESS) && !rst;
  assign mem_wr      = mem_enable && lat_wr;
  assign mem_addr    = {lat_addr[ADDR_WIDTH-1:1], 1'b0};
  assign mem_data_in = lat_wdata;

  assign i_done = (state == DONE) && (owner == OWN_I) && !rst;
  assign d_done = (state == DONE) && (owner == OWN_D) && !rst;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table plus hand-written
// timing, collision, mid-access reset and LATENCY=1 sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_done, d_done, busy, mem_enable, mem_wr;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

  logic        i_req1;
  logic [15:0] i_addr1;
  logic        i_done1, d_done1, busy1, mem_enable1, mem_wr1;
  logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_data_in1, mem_data_out1;

  logic [15:0] mem [0:255];
  logic        loaded = 1'b0;

  int total_checks  = 0;
  int passed_checks = 0;
  logic [15:0] exp_i_rdata = 16'h0000;
  logic [15:0] exp_d_rdata = 16'h0000;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_done(d_done1), .d_rdata(d_rdata1), .busy(busy1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_enable(mem_enable1),
    .mem_wr(mem_wr1), .mem_data_out(mem_data_out1)
  );

  // Memory image loads on the first reset only, so aborted stores stay visible.
  always @(posedge clk) begin
    if (rst && !loaded) begin
      for (int w = 0; w < 256; w++) mem[w] <= 16'hA000 + 16'(w);
      mem[8'h08] <= 16'h1234;
      mem[8'h18] <= 16'h5555;
      loaded <= 1'b1;
    end else begin
      if (mem_enable && mem_wr) mem[mem_addr[8:1]] <= mem_data_in;
      if (mem_enable1 && mem_wr1) mem[mem_addr1[8:1]] <= mem_data_in1;
    end
  end

  assign mem_data_out  = mem[mem_addr[8:1]];
  assign mem_data_out1 = mem[mem_addr1[8:1]];

  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        exp_d_port;
    logic [15:0] exp_rdata;
    int          exp_wr_pulses;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one single-port transaction from an IDLE cycle and checks its outcome.
  task automatic applyStimulus(input string tag, input vec_t v);
    int   cyc;
    int   wr_pulses;
    bit   seen;
    logic got_d;
    logic got_i;
    cyc = 0; wr_pulses = 0; seen = 0; got_d = 0; got_i = 0;
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_wr = v.d_wr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (mem_wr) wr_pulses++;
      if (i_done || d_done) begin
        seen  = 1;
        got_d = d_done;
        got_i = i_done;
        i_req = 0;
        d_req = 0;
      end
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_cycle"}, cyc, 5);
    checkOutput({tag, "_port"}, {got_d, got_i}, v.exp_d_port ? 2'b10 : 2'b01);
    checkOutput({tag, "_wr"}, wr_pulses, v.exp_wr_pulses);
    if (!(v.d_req && v.d_wr)) begin
      if (v.exp_d_port) exp_d_rdata = v.exp_rdata;
      else              exp_i_rdata = v.exp_rdata;
    end
    checkOutput({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
    checkOutput({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
    tick();
    checkOutput({tag, "_idle"}, {busy, i_done, d_done}, 3'b000);
  endtask

  vec_t table_v [7];
  vec_t v;
  int   i_cyc, d_cyc, wr_cnt;

  initial begin
    table_v[0] = '{0, 16'h0000, 1, 1, 16'h0020, 16'hBEEF, 1, 16'h0000, 1};
    table_v[1] = '{0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 16'hBEEF, 0};
    table_v[2] = '{1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0};
    table_v[3] = '{0, 16'h0000, 1, 1, 16'h0041, 16'hCAFE, 1, 16'h0000, 1};
    table_v[4] = '{1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 16'hCAFE, 0};
    table_v[5] = '{0, 16'h0000, 1, 0, 16'h0003, 16'h0000, 1, 16'hA001, 0};
    table_v[6] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0};

    rst = 1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; i_req1 = 0; i_addr1 = 0;
    #1;
    checkOutput("rst_mem_enable", {mem_enable, mem_wr}, 2'b00);
    repeat (3) tick();
    rst = 0;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", {i_done, d_done}, 2'b00);
    checkOutput("rst_rdata", {i_rdata, d_rdata}, 32'h0);
    checkOutput("rst_mem_out", {mem_enable, mem_wr, mem_addr, mem_data_in}, 34'h0);

    // Single fetch, cycle-accurate.
    i_req = 1; i_addr = 16'h0010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("fetch_en_c%0d", k), mem_enable, 32'(k == 4));
      checkOutput($sformatf("fetch_wr_c%0d", k), mem_wr, 1'b0);
      checkOutput($sformatf("fetch_idone_c%0d", k), i_done, 32'(k == 5));
      checkOutput($sformatf("fetch_ddone_c%0d", k), d_done, 1'b0);
      if (k == 4) checkOutput("fetch_addr", mem_addr, 16'h0010);
      if (k == 5) begin
        checkOutput("fetch_rdata", i_rdata, 16'h1234);
        i_req = 0;
      end
    end
    exp_i_rdata = 16'h1234;

    for (int n = 0; n < 7; n++) applyStimulus($sformatf("v%0d", n), table_v[n]);

    // Collision after an I grant: D wins in both arbitration modes.
    i_req = 1; i_addr = 16'h0010; d_req = 1; d_wr = 0; d_addr = 16'h0020;
    i_cyc = 0; d_cyc = 0;
    for (int k = 1; k <= 16 && (i_cyc == 0 || d_cyc == 0); k++) begin
      tick();
      if (d_done) begin d_cyc = k; d_req = 0; end
      if (i_done) begin i_cyc = k; i_req = 0; end
    end
    checkOutput("prio_d_cycle", d_cyc, 5);
    checkOutput("prio_i_cycle", i_cyc, 11);
    checkOutput("prio_rdata", {i_rdata, d_rdata}, {16'h1234, 16'hBEEF});
    tick();

    // Collision after a D grant distinguishes round-robin from fixed priority.
    v = '{0, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 16'hA001, 0};
    applyStimulus("pre_rr", v);
    i_req = 1; i_addr = 16'h0002; d_req = 1; d_wr = 0; d_addr = 16'h0020;
    i_cyc = 0; d_cyc = 0;
    for (int k = 1; k <= 16 && (i_cyc == 0 || d_cyc == 0); k++) begin
      tick();
      if (d_done) begin d_cyc = k; d_req = 0; end
      if (i_done) begin i_cyc = k; i_req = 0; end
    end
`ifdef MEM_ARB_RR_EN
    checkOutput("arb_i_cycle", i_cyc, 5);
    checkOutput("arb_d_cycle", d_cyc, 11);
`else
    checkOutput("arb_d_cycle", d_cyc, 5);
    checkOutput("arb_i_cycle", i_cyc, 11);
`endif
    checkOutput("arb_rdata", {i_rdata, d_rdata}, {16'hA001, 16'hBEEF});
    tick();

    // Store aborted by reset during WAIT must never reach memory.
    d_req = 1; d_wr = 1; d_addr = 16'h0030; d_wdata = 16'h7777;
    wr_cnt = 0;
    tick();
    tick();
    rst = 1;
    checkOutput("abort_en_in_rst", mem_enable, 1'b0);
    tick();
    rst = 0; d_req = 0; d_wr = 0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_rdata", {i_rdata, d_rdata}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (mem_wr || d_done) wr_cnt++;
      tick();
    end
    checkOutput("abort_no_activity", wr_cnt, 0);
    exp_i_rdata = 16'h0000;
    exp_d_rdata = 16'h0000;
    v = '{0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 1, 16'h5555, 0};
    applyStimulus("abort_load", v);

    // LATENCY=1 instance with an odd fetch address.
    i_req1 = 1; i_addr1 = 16'h0011;
    tick();
    checkOutput("lat1_en", mem_enable1, 1'b1);
    checkOutput("lat1_addr", mem_addr1, 16'h0010);
    tick();
    checkOutput("lat1_done", i_done1, 1'b1);
    checkOutput("lat1_rdata", i_rdata1, 16'h1234);
    i_req1 = 0;
    tick();
    checkOutput("lat1_idle", {busy1, i_done1}, 2'b00);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, byte-addressed, 16-bit unified memory between the fetch stage (I-port, read-only) and the memory stage (D-port, read/write).
- Models a multi-cycle memory by inserting LATENCY cycles per access. Each requester sees one-shot completion plus registered read data.
- Sits between pipeline stages and the memory instance. Drives memory enable/wr/addr/data_in and consumes its combinational data_out.

Parameters:
- ADDR_WIDTH, 16, byte-address width of all ports.
- LATENCY, 4, cycles from accept to memory access cycle, inclusive. Legal range 1..15; other values are a compile-time error.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_req  input  1  fetch request, held until i_done
- i_addr  input  ADDR_WIDTH  fetch byte address
- i_done  output  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  output  16  fetch read data, registered, held until next I completion
- d_req  input  1  data request, held until d_done
- d_wr  input  1  1 = store, 0 = load
- d_addr  input  ADDR_WIDTH  data byte address
- d_wdata  input  16  store data
- d_done  output  1  one-cycle pulse: data access complete
- d_rdata  output  16  load read data, registered, held until next D load completion
- busy  output  1  state != IDLE
- mem_addr  output  ADDR_WIDTH  to memory addr
- mem_data_in  output  16  to memory data_in
- mem_enable  output  1  to memory enable
- mem_wr  output  1  to memory wr
- mem_data_out  input  16  from memory data_out, combinational read

Behaviour:
- States: IDLE, WAIT, ACCESS, DONE.
- Reset values: state=IDLE, wait counter=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, busy=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0, last_grant=I.
- While rst is high, mem_enable=0 and mem_wr=0 unconditionally. The memory performs its image load during reset and must see no accesses.
- IDLE:
  - If any req is high, arbitrate and latch owner, addr, wdata and wr (wr forced 0 for I).
  - Go to ACCESS if LATENCY=1, else to WAIT with counter=LATENCY-2.
- WAIT:
  - Counter decrements each cycle.
  - At 0, go to ACCESS.
  - Memory outputs are idle (enable=0).
- ACCESS (exactly one cycle):
  - mem_enable=1, mem_wr=latched wr, mem_addr={latched addr[ADDR_WIDTH-1:1],1'b0}, mem_data_in=latched wdata.
  - A store commits at the closing edge.
  - A load registers mem_data_out into the owner's rdata at the closing edge.
- DONE (one cycle):
  - Owner's done=1.
  - Unconditionally return to IDLE.
- Timing: request sampled in IDLE at cycle T → ACCESS at T+LATENCY → done at T+LATENCY+1 → next accept no earlier than T+LATENCY+2.
- Requester rule: the requester drops req or presents a new request in the cycle after done. Latched fields make mid-access changes to req/addr/wdata harmless.
- Default arbitration is fixed priority: D wins over I on a simultaneous request.
- A req that drops while not granted is simply not served; no queuing.
- addr[0] is ignored; odd addresses access the aligned word.
- Reset mid-operation: abort immediately. A store not yet in ACCESS is never written. No done pulse; rdata is cleared to 0.
- The non-owner's rdata and done are unaffected by the other port's access.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the port not granted last wins. last_grant updates on every accept. Single requests are always granted.
- Undefined: fixed D-over-I priority. The last_grant register is not built.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, WAIT, ACCESS, DONE);
  - owner enum (OWN_I, OWN_D);
  - localparam CNT_W=4;
  - the LATENCY range check constant.
- One sub-module, mem_arb_pick: a grant selector with inputs i_req, d_req and last_grant, and a one-hot grant output. It holds the RR/fixed logic under MEM_ARB_RR_EN.
- FSM, counter and data registers stay in mem_arbiter.

Test Plan:
- LATENCY=4, mem[0x0010]=0x1234, i_req at cycle 0 with i_addr=0x0010 → mem_enable=1/mem_wr=0 only at cycle 4, i_done pulse at cycle 5, i_rdata=0x1234, d_done stays 0.
- d_req store d_addr=0x0020, d_wdata=0xBEEF, then load 0x0020 → mem_wr=1 for exactly one cycle, load d_rdata=0xBEEF, i_rdata unchanged.
- i_req and d_req both asserted at cycle 0, fixed priority → d_done at cycle 5, I accepted at cycle 6, i_done at cycle 11. With MEM_ARB_RR_EN repeated back-to-back pairs → grants alternate D,I,D,I.
- Store to 0x0030 (old value 0x5555), rst pulsed during WAIT at cycle 2 → no mem_wr pulse, no d_done, busy=0 the cycle after rst; a later load returns 0x5555.
- i_addr=0x0011 with LATENCY=1 → mem_addr=0x0010 at cycle 1, i_done at cycle 2, data equals word at 0x0010.
